// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the round-robin register-write arbiter
//
// Purpose: FSM state encoding, index-width and one-hot helpers used by
//          rr_pick and rr_reg_write_arbiter.
// Contents:
//   state_e  IDLE / GRANT
//   MAX_N    largest supported requester count
//   idx_w    bits needed to index n requesters (never less than 1)
//   onehot   MAX_N-bit vector with only bit idx set (all-zero if idx out of range)
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int MAX_N = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n && idx < MAX_N) begin
      r[0] = 1'b1;
      r    = r << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
//
// Purpose: find the first set request at or after ptr_i, wrapping N-1 -> 0.
// Ports:
//   req_i     in  N    request vector
//   ptr_i     in  IW   round-robin start position
//   any_o     out 1    at least one request is set
//   winner_o  out IW   index of the selected requester (0 when any_o=0)
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester ptr_i.
    dbl      = {req_i, req_i};
    rot      = N'(dbl >> ptr_i);
    any_o    = |req_i;
    winner_o = '0;
    sum      = '0;
    // Scan from the far end so the lowest rotated offset is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr_i} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        winner_o = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_reg_write_arbiter.sv
// rtl/rr_reg_write_arbiter.sv - round-robin arbiter sharing one W-bit register among N writers
//
// Purpose: one-hot registered grant, one write beat per grant, back-to-back
//          grants under load, saturating write counter.
// Ports:
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      synchronous active-high reset
//   req      in   N      req[i]: requester i wants a write
//   wdata    in   N*W    requester i data at wdata[i*W +: W]
//   gnt      out  N      registered one-hot grant, zero when idle
//   q        out  W      shared register contents
//   q_valid  out  1      a write has completed since reset
//   owner    out  IW     index of the last writer
//   wr_cnt   out  CNT_W  completed writes since reset, saturating
module rr_reg_write_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int IW    = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     q,
  output logic             q_valid,
  output logic [IW-1:0]    owner,
  output logic [CNT_W-1:0] wr_cnt
);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]    gidx_q, gidx_d;   // encoded form of gnt_q
  logic [W-1:0]     q_q, q_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             q_valid_q, q_valid_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [W-1:0]     wd [N];
  logic             do_write;
  logic             pick_any;
  logic [IW-1:0]    pick_winner;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wd[i] = wdata[i*W +: W];
    end
  end

  // The picker sees the pointer as it will be after this cycle's write,
  // so a back-to-back grant already honours the rotation.
  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_d),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  // State register: every piece of state shares the one reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gidx_q    <= '0;
      q_q       <= '0;
      owner_q   <= '0;
      q_valid_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      q_q       <= q_d;
      owner_q   <= owner_d;
      q_valid_q <= q_valid_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    q_d       = q_q;
    owner_d   = owner_q;
    q_valid_d = q_valid_q;
    wr_cnt_d  = wr_cnt_q;

    // A grant whose requester dropped req is an abort: nothing changes.
    do_write = (state_q == GRANT) && req[gidx_q];

    if (do_write) begin
      q_d       = wd[gidx_q];
      owner_d   = gidx_q;
      q_valid_d = 1'b1;
      if (wr_cnt_q != {CNT_W{1'b1}}) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
    end

    // IDLE and GRANT re-arbitrate identically; in IDLE ptr_d equals ptr_q.
    if (pick_any) begin
      state_d = GRANT;
      gnt_d   = N'(onehot(int'(pick_winner), N));
      gidx_d  = pick_winner;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      gidx_d  = '0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt     = gnt_q;
    q       = q_q;
    q_valid = q_valid_q;
    owner   = owner_q;
    wr_cnt  = wr_cnt_q;
  end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// tb/tb_rr_reg_write_arbiter.sv - directed self-checking bench for rr_reg_write_arbiter
module tb_rr_reg_write_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [1:0]       owner;
  logic [CNT_W-1:0] wr_cnt;

  int checks;
  int errors;

  rr_reg_write_arbiter #(
    .N     (N),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                         input logic e_qv, input logic [1:0] e_own, input logic [3:0] e_cnt);
    chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    chk({tag, ".q"},       32'(q),       32'(e_q));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(e_qv));
    chk({tag, ".owner"},   32'(owner),   32'(e_own));
    chk({tag, ".wr_cnt"},  32'(wr_cnt),  32'(e_cnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 4'b1111;
    wdata  = {8'h13, 8'h12, 8'h11, 8'h10};

    // 1. Reset held two cycles with all requests up.
    step();
    chk_all("rst1", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);
    step();
    chk_all("rst2", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);
    rst = 1'b0;
    req = 4'b0000;
    step();
    chk_all("idle", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);

    // 2. Single write from requester 2.
    req   = 4'b0100;
    wdata = {8'h13, 8'hA5, 8'h11, 8'h10};
    step();
    chk_all("single.gnt", 4'b0100, 8'h00, 1'b0, 2'd0, 4'd0);
    step();
    // req still held at the write edge, so a sole requester is re-granted.
    chk_all("single.wr", 4'b0100, 8'hA5, 1'b1, 2'd2, 4'd1);
    req = 4'b0000;
    step();
    chk_all("single.abort", 4'b0000, 8'hA5, 1'b1, 2'd2, 4'd1);

    // 3. Rotation from a fresh pointer.
    rst = 1'b1;
    step();
    chk_all("rst3", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);
    rst   = 1'b0;
    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    chk_all("rot0", 4'b0001, 8'h00, 1'b0, 2'd0, 4'd0);
    step();
    chk_all("rot1", 4'b0010, 8'h10, 1'b1, 2'd0, 4'd1);
    step();
    chk_all("rot2", 4'b0100, 8'h11, 1'b1, 2'd1, 4'd2);
    step();
    chk_all("rot3", 4'b1000, 8'h12, 1'b1, 2'd2, 4'd3);
    step();
    chk_all("rot4", 4'b0001, 8'h13, 1'b1, 2'd3, 4'd4);
    req = 4'b0000;
    step();
    chk_all("rot.end", 4'b0000, 8'h13, 1'b1, 2'd3, 4'd4);

    // 4. Abort: requester 1 drops req in its grant cycle; ptr stays at 0.
    req = 4'b0010;
    step();
    chk_all("abort.gnt", 4'b0010, 8'h13, 1'b1, 2'd3, 4'd4);
    req = 4'b0000;
    step();
    chk_all("abort.nowr", 4'b0000, 8'h13, 1'b1, 2'd3, 4'd4);
    req = 4'b1010;
    step();
    chk_all("abort.ptr", 4'b0010, 8'h13, 1'b1, 2'd3, 4'd4);
    step();
    chk_all("abort.next", 4'b1000, 8'h11, 1'b1, 2'd1, 4'd5);

    // 5. Reset while requester 3 holds the grant; its write is dropped.
    wdata = {8'hFF, 8'h12, 8'h11, 8'h10};
    rst   = 1'b1;
    step();
    chk_all("midrst", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);
    rst = 1'b0;
    req = 4'b1001;
    step();
    chk_all("midrst.g0", 4'b0001, 8'h00, 1'b0, 2'd0, 4'd0);
    step();
    chk_all("midrst.w0", 4'b1000, 8'h10, 1'b1, 2'd0, 4'd1);
    step();
    chk_all("midrst.w3", 4'b0001, 8'hFF, 1'b1, 2'd3, 4'd2);

    // 6. Saturation: a sole requester writes every cycle.
    rst = 1'b1;
    req = 4'b0000;
    step();
    chk_all("rst6", 4'b0000, 8'h00, 1'b0, 2'd0, 4'd0);
    rst = 1'b0;
    req = 4'b0001;
    step();
    chk("sat.gnt0", 32'(gnt), 32'h1);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat.cnt%0d", i), 32'(wr_cnt), (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("sat.gnt%0d", i), 32'(gnt), 32'h1);
    end
    chk("sat.q", 32'(q), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
